msb_pg_sched: RTL

//  Power-gating scheduler for the MSB half (MSB_RCA) of the 32-bit split adder.
//  - Watches MSB-operand activity and gates the domain after a programmable idle period.
//  - Sequences iso_en/ret_en/pse in a fixed order for sleep and wake.
//  - Grants msb_ready to the datapath only when the domain is fully on and de-isolated.
//  - Sits beside the LSB_RCA/MSB_RCA pair inside RCA_32 and replaces direct p-driven control.

---
 rtl/msb_pg_sched_pkg.sv | 36 +++
 rtl/msb_pg_sched_if.sv | 23 ++
 rtl/msb_pg_sched_delay_cnt.sv | 24 ++
 rtl/msb_pg_sched.sv | 98 +++++++++
 4 files changed

// File: rtl/msb_pg_sched_pkg.sv
// Shared state encodings and per-state output table for the MSB power-gating scheduler.
// Rail bundle order everywhere is {iso_en, ret_en, pse, msb_ready}.
package msb_pg_sched_pkg;

   localparam logic [2:0] ST_ON      = 3'd0;
   localparam logic [2:0] ST_ISO     = 3'd1;
   localparam logic [2:0] ST_RET     = 3'd2;
   localparam logic [2:0] ST_OFF     = 3'd3;
   localparam logic [2:0] ST_PWRUP   = 3'd4;
   localparam logic [2:0] ST_RESTORE = 3'd5;
   localparam logic [2:0] ST_UNISO   = 3'd6;

   localparam logic [3:0] OUT_ON      = 4'b0011;
   localparam logic [3:0] OUT_ISO     = 4'b1010;
   localparam logic [3:0] OUT_RET     = 4'b1110;
   localparam logic [3:0] OUT_OFF     = 4'b1100;
   localparam logic [3:0] OUT_PWRUP   = 4'b1110;
   localparam logic [3:0] OUT_RESTORE = 4'b1010;
   localparam logic [3:0] OUT_UNISO   = 4'b0010;

   function automatic logic [3:0] state_outputs(input logic [2:0] st);
      logic [3:0] o;
      o = OUT_ON;
      case (st)
         ST_ISO:     o = OUT_ISO;
         ST_RET:     o = OUT_RET;
         ST_OFF:     o = OUT_OFF;
         ST_PWRUP:   o = OUT_PWRUP;
         ST_RESTORE: o = OUT_RESTORE;
         ST_UNISO:   o = OUT_UNISO;
         default:    o = OUT_ON;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/msb_pg_sched_if.sv
// Datapath-side request and power-control signals of the MSB gating scheduler.
interface msb_pg_sched_if #(
   parameter int unsigned STAT_W = 16
);
   logic              need_msb;
   logic              gate_en;
   logic              iso_en;
   logic              ret_en;
   logic              pse;
   logic              msb_ready;
   logic [2:0]        state_o;
   logic [STAT_W-1:0] sleep_cnt;

   modport master (
      output need_msb, gate_en,
      input  iso_en, ret_en, pse, msb_ready, state_o, sleep_cnt
   );

   modport slave (
      input  need_msb, gate_en,
      output iso_en, ret_en, pse, msb_ready, state_o, sleep_cnt
   );
endinterface

// File: rtl/msb_pg_sched_delay_cnt.sv
// Up-counter with synchronous clear and terminal compare; shared by idle and power-up timing.
module msb_pg_sched_delay_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_tc
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc)
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_tc = (r_cnt == i_term);
endmodule

// File: rtl/msb_pg_sched.sv
// Power-gating sequencer for the MSB adder half: idle-timed sleep entry, ordered wake,
// registered Moore outputs and a saturating count of completed OFF entries.
module msb_pg_sched
   import msb_pg_sched_pkg::*;
#(
   parameter int unsigned IDLE_CYC  = 8,
   parameter int unsigned PWRUP_CYC = 4,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned STAT_W    = 16
) (
   input logic                 CLK,
   input logic                 rst_n,
   msb_pg_sched_if.slave       bus
);
   localparam logic [CNT_W-1:0] IDLE_TERM  = CNT_W'(IDLE_CYC - 1);
   localparam logic [CNT_W-1:0] PWRUP_TERM = CNT_W'(PWRUP_CYC - 1);

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [3:0]        r_out;
   logic [STAT_W-1:0] r_sleep_cnt;
   logic              w_idle;
   logic              w_wake;
   logic              w_clr;
   logic              w_inc;
   logic              w_tc;
   logic [CNT_W-1:0]  w_term;

   assign w_idle = ~bus.need_msb & bus.gate_en;
   assign w_wake = bus.need_msb | ~bus.gate_en;

   // The counter is only live while idling in ON or powering up; every other state clears it,
   // so both ON and PWRUP are always entered with a zero count.
   always_comb begin
      w_next = r_state;
      w_clr  = 1'b1;
      w_inc  = 1'b0;
      w_term = IDLE_TERM;
      case (r_state)
         ST_ON: begin
            if (w_idle) begin
               w_clr = 1'b0;
               w_inc = 1'b1;
               if (w_tc)
                  w_next = ST_ISO;
            end
         end
         ST_ISO:  w_next = ST_RET;
         ST_RET:  w_next = ST_OFF;
         ST_OFF: begin
            if (w_wake)
               w_next = ST_PWRUP;
         end
         ST_PWRUP: begin
            w_clr  = 1'b0;
            w_inc  = 1'b1;
            w_term = PWRUP_TERM;
            if (w_tc)
               w_next = ST_RESTORE;
         end
         ST_RESTORE: w_next = ST_UNISO;
         ST_UNISO:   w_next = ST_ON;
         default:    w_next = ST_ON;
      endcase
   end

   msb_pg_sched_delay_cnt #(
      .CNT_W (CNT_W)
   ) u_dly (
      .i_clk   (CLK),
      .i_rst_n (rst_n),
      .i_clr   (w_clr),
      .i_inc   (w_inc),
      .i_term  (w_term),
      .o_tc    (w_tc)
   );

   // Outputs register the decode of the next state so rails move on the same edge as state.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ON;
         r_out       <= OUT_ON;
         r_sleep_cnt <= '0;
      end else begin
         r_state <= w_next;
         r_out   <= state_outputs(w_next);
         if (w_next == ST_OFF && r_state != ST_OFF && r_sleep_cnt != '1)
            r_sleep_cnt <= r_sleep_cnt + STAT_W'(1);
      end
   end

   assign bus.iso_en    = r_out[3];
   assign bus.ret_en    = r_out[2];
   assign bus.pse       = r_out[1];
   assign bus.msb_ready = r_out[0];
   assign bus.state_o   = r_state;
   assign bus.sleep_cnt = r_sleep_cnt;
endmodule
